// File: rtl/ysyx_25040111_ifu.sv
// ysyx_25040111_ifu: fetches one instruction per PC over AXI4-Lite AR/R and hands it to decode.
// Optional IFU_ALIGN_CHECK_EN: misaligned PCs skip the bus and return NOP with fetch_err set.
module ysyx_25040111_ifu #(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              pc_valid,
    output logic              pc_ready,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic              fetch_err,
    output logic              drop_err
);
    typedef enum logic [1:0] {IDLE, AR, R, OUT} state_e;
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d, inst_pc_q, inst_pc_d, pend_pc_q, pend_pc_d, tgt;
    logic [31:0]       inst_q, inst_d;
    logic              pend_q, pend_d, fetch_err_q, fetch_err_d, drop_err_q, drop_err_d;
    logic              pc_ready_q, pc_ready_d;
    always_comb begin
        state_d     = state_q;
        araddr_d    = araddr_q;
        inst_pc_d   = inst_pc_q;
        pend_pc_d   = pend_pc_q;
        inst_d      = inst_q;
        pend_d      = pend_q;
        fetch_err_d = fetch_err_q;
        drop_err_d  = drop_err_q;
        pc_ready_d  = 1'b0;
        tgt         = pend_q ? pend_pc_q : pc_in;
        case (state_q)
            IDLE: if (pend_q || pc_valid) begin
                araddr_d = tgt;
                pend_d   = 1'b0;
                state_d  = AR;
`ifdef IFU_ALIGN_CHECK_EN
                if (tgt[1:0] != 2'b00) begin
                    state_d     = OUT;
                    inst_d      = NOP_INST;
                    inst_pc_d   = tgt;
                    fetch_err_d = 1'b1;
                end
`endif
            end
            AR: state_d = arready ? R : AR;
            R: if (rvalid) begin
                state_d     = OUT;
                inst_d      = rdata;
                inst_pc_d   = araddr_q;
                fetch_err_d = rresp != 2'b00;
            end
            OUT: if (inst_ready) begin
                state_d     = IDLE;
                pc_ready_d  = 1'b1;
                inst_d      = NOP_INST;
                fetch_err_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        // In IDLE the slot is being drained this cycle, so a new PC can refill it
        if (pc_valid && (state_q != IDLE || pend_q)) begin
            if (state_q != IDLE && pend_q) begin
                drop_err_d = 1'b1;
            end else begin
                pend_d    = 1'b1;
                pend_pc_d = pc_in;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            araddr_q    <= '0;
            inst_pc_q   <= '0;
            pend_pc_q   <= '0;
            inst_q      <= NOP_INST;
            pend_q      <= 1'b0;
            fetch_err_q <= 1'b0;
            drop_err_q  <= 1'b0;
            pc_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            araddr_q    <= araddr_d;
            inst_pc_q   <= inst_pc_d;
            pend_pc_q   <= pend_pc_d;
            inst_q      <= inst_d;
            pend_q      <= pend_d;
            fetch_err_q <= fetch_err_d;
            drop_err_q  <= drop_err_d;
            pc_ready_q  <= pc_ready_d;
        end
    end
    assign arvalid    = state_q == AR;
    assign rready     = state_q == R;
    assign inst_valid = state_q == OUT;
    assign araddr     = araddr_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign fetch_err  = fetch_err_q;
    assign drop_err   = drop_err_q;
    assign pc_ready   = pc_ready_q;
endmodule

// File: doc/ysyx_25040111_ifu.md
Name: ysyx_25040111_ifu

Overview:
- Instruction fetch unit: the consumer of the PC unit's pc/valid handshake.
- Latches each PC the PC unit publishes, issues one AXI4-Lite read (AR/R channels only) for the instruction word, and presents the fetched instruction plus its PC to the decode stage with a valid/ready handshake.
- Asserts the PC unit's advance signal (pc_ready) only when decode has accepted the instruction. The PC unit therefore never runs ahead of fetch.

Parameters:
- ADDR_W, 32, address/PC width
- NOP_INST, 32'h00000013, instruction word driven on inst while no fetch result is held

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- pc_in  input  ADDR_W  PC from PC unit
- pc_valid  input  1  one-cycle pulse: pc_in is a new fetch target
- pc_ready  output  1  one-cycle pulse: instruction accepted downstream, PC unit may advance
- araddr  output  ADDR_W  AXI read address
- arvalid  output  1  AXI AR valid
- arready  input  1  AXI AR ready
- rdata  input  32  AXI read data
- rresp  input  2  AXI read response
- rvalid  input  1  AXI R valid
- rready  output  1  AXI R ready
- inst  output  32  fetched instruction
- inst_pc  output  ADDR_W  PC of inst
- inst_valid  output  1  inst/inst_pc valid to decode
- inst_ready  input  1  decode accepts
- fetch_err  output  1  qualifies inst_valid: bus error (rresp != 2'b00) or misaligned PC
- drop_err  output  1  sticky: pc_valid arrived while the pending slot was full

Behaviour:
- Reset (clk edge with reset=1) forces the following, regardless of state, and abandons any in-flight transaction. The bus slave shares this reset, so no drain is performed.
  - state=IDLE, arvalid=0, rready=0, inst_valid=0, pc_ready=0, fetch_err=0, drop_err=0
  - inst=NOP_INST, inst_pc=0, araddr=0, pending flag cleared
- FSM states: IDLE, AR, R, OUT.
  - IDLE: on pc_valid, latch pc_in into araddr -> AR. If the pending flag is set, use the pending PC instead and clear the flag.
  - AR: arvalid=1, araddr stable. On arvalid&arready -> R. arvalid must not drop before the handshake.
  - R: rready=1. On rvalid&rready -> OUT, capturing inst=rdata, inst_pc=araddr, fetch_err=(rresp!=0).
  - OUT: inst_valid=1, outputs held stable until inst_ready. On inst_valid&inst_ready:
    - pulse pc_ready for exactly one cycle
    - set inst_valid=0 and inst=NOP_INST
    - -> IDLE
- Latency: with pc_valid at cycle 0, arready=1 at cycle 1 and rvalid=1 at cycle 2, the sequence is:
  - arvalid high in cycle 1
  - inst_valid high in cycle 3
  - pc_ready pulses in the cycle after the inst_ready handshake
- Pending slot: one entry. A pc_valid seen in any state other than IDLE stores pc_in and sets the pending flag. It is consumed on the next IDLE entry; IDLE then goes straight to AR with no idle bubble.
- pc_valid while the pending flag is already set: the new PC is dropped and drop_err is set. drop_err stays set until reset.
- pc_valid and the pending-slot consume in the same IDLE cycle: the pending PC is fetched, and the new pc_in goes into the slot.
- rvalid while not in R is ignored; rready=0 outside R.
- Bus error: the instruction is still delivered, with fetch_err=1. pc_ready behaviour is unchanged.

Optional Feature:
- Macro: IFU_ALIGN_CHECK_EN.
- Defined: in IDLE, a latched PC with araddr[1:0]!=0 skips AR/R and goes directly to OUT. In that case inst=NOP_INST, inst_pc=the PC, fetch_err=1, and no AXI traffic is generated.
- Undefined: no alignment check. Every PC is issued on AR as-is.

Test Plan:
- Reset, then pc_valid with pc_in=32'h80000000, arready=1, rvalid=1 in cycle 2 with rdata=32'h00100093, rresp=0, inst_ready=1 -> araddr=32'h80000000 with arvalid in cycle 1; inst=32'h00100093, inst_pc=32'h80000000, inst_valid in cycle 3; pc_ready pulses exactly once in cycle 4.
- Backpressure: arready=0 for 5 cycles then 1; rvalid delayed 4 cycles; inst_ready=0 for 3 cycles -> arvalid/araddr, then inst/inst_pc/inst_valid held stable; single pc_ready pulse.
- rresp=2'b10 for pc 32'h80000004 -> inst_valid=1, fetch_err=1, inst=rdata, pc_ready still pulses.
- pc_valid 32'h80000008 during R, then 32'h8000000C during OUT -> the first is fetched next with no IDLE bubble; the second is dropped; drop_err=1 and stays 1.
- Reset asserted while in R -> next cycle arvalid=0, rready=0, inst_valid=0; a subsequent pc_valid 32'h30000000 fetches normally.
- With IFU_ALIGN_CHECK_EN, pc_in=32'h80000002 -> no arvalid; inst_valid=1, fetch_err=1, inst=32'h00000013, inst_pc=32'h80000002. Without the macro, arvalid asserts with araddr=32'h80000002.
